// File: rtl/proc_io_pkg.sv
// Shared helpers and defaults for the processor I/O hub.
package proc_io_pkg;

  localparam int unsigned NUBITS_DEF = 32;
  localparam int unsigned ODEPTH_DEF = 4;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Channel-select width: never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO for one output channel; head word is visible while not empty.
module io_fifo
  import proc_io_pkg::*;
#(
  parameter int unsigned NUBITS = NUBITS_DEF,
  parameter int unsigned ODEPTH = ODEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [NUBITS-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [NUBITS-1:0] head
);

  localparam int unsigned PW = clog2(ODEPTH);
  localparam int unsigned CW = PW + 1;

  logic [NUBITS-1:0] mem [ODEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(ODEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A full FIFO never accepts, even when it pops the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy tracking; pointers wrap naturally at ODEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are irrelevant while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/proc_io_hub.sv
// Buffered multi-channel I/O hub between the core I/O bus and streaming channels.
// Optional stall watchdog enabled by defining IO_TIMEOUT_EN.
module proc_io_hub
  import proc_io_pkg::*;
#(
  parameter int unsigned NUBITS = NUBITS_DEF,
  parameter int unsigned NUIOIN = 1,
  parameter int unsigned NUIOOU = 2,
  parameter int unsigned ODEPTH = ODEPTH_DEF,
  parameter int unsigned TMOUT  = 1024,
  localparam int unsigned AO = addr_w(NUIOOU),
  localparam int unsigned AI = addr_w(NUIOIN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_out_en,
  input  logic [AO-1:0]            proc_addr_out,
  input  logic signed [NUBITS-1:0] proc_data_out,
  input  logic                     proc_req_in,
  input  logic [AI-1:0]            proc_addr_in,
  output logic [NUBITS-1:0]        proc_data_in,
  output logic                     proc_stall,
  output logic [NUIOOU*NUBITS-1:0] out_data,
  output logic [NUIOOU-1:0]        out_valid,
  input  logic [NUIOOU-1:0]        out_ready,
  input  logic [NUIOIN*NUBITS-1:0] in_data,
  input  logic [NUIOIN-1:0]        in_valid,
  output logic [NUIOIN-1:0]        in_ready,
  output logic                     io_err
);

  logic [NUIOOU-1:0] fifo_full;
  logic [NUIOOU-1:0] fifo_empty;
  logic [NUIOOU-1:0] fifo_push;
  logic [NUIOOU-1:0] fifo_pop;

  logic [NUIOIN-1:0] hold_full;
  logic [NUBITS-1:0] hold_data [NUIOIN];

  logic              wr_av;
  logic              rd_av;
  logic              wr_full_sel;
  logic              rd_full_sel;
  logic [NUBITS-1:0] rd_data_sel;
  logic              stall_raw;
  logic              wr_acc;
  logic              rd_acc;
  logic              tmo_hit;

  assign wr_av = (32'(proc_addr_out) < NUIOOU);
  assign rd_av = (32'(proc_addr_in) < NUIOIN);

  // Select the addressed FIFO/holding-register status without out-of-range indexing.
  always_comb begin
    wr_full_sel = 1'b0;
    rd_full_sel = 1'b0;
    rd_data_sel = '0;
    for (int unsigned k = 0; k < NUIOOU; k++) begin
      if (32'(proc_addr_out) == k) wr_full_sel = fifo_full[k];
    end
    for (int unsigned j = 0; j < NUIOIN; j++) begin
      if (32'(proc_addr_in) == j) begin
        rd_full_sel = hold_full[j];
        rd_data_sel = hold_data[j];
      end
    end
  end

  // Either side blocking holds both; nothing takes effect on a blocked or timed-out cycle.
  always_comb begin
    stall_raw    = (proc_out_en & wr_av & wr_full_sel) | (proc_req_in & rd_av & ~rd_full_sel);
    wr_acc       = proc_out_en & wr_av & ~stall_raw;
    rd_acc       = proc_req_in & rd_av & ~stall_raw;
    proc_stall   = stall_raw & ~tmo_hit;
    proc_data_in = (proc_req_in & rd_av & ~tmo_hit) ? rd_data_sel : '0;
  end

  // Per-channel push/pop strobes.
  always_comb begin
    fifo_push = '0;
    for (int unsigned k = 0; k < NUIOOU; k++) begin
      if (32'(proc_addr_out) == k) fifo_push[k] = wr_acc;
    end
    fifo_pop  = out_ready & ~fifo_empty;
    out_valid = ~fifo_empty;
  end

  // One FIFO per output channel, head word driven straight onto the channel.
  for (genvar k = 0; k < int'(NUIOOU); k++) begin : g_out
    io_fifo #(
      .NUBITS (NUBITS),
      .ODEPTH (ODEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[k]),
      .din   (proc_data_out),
      .pop   (fifo_pop[k]),
      .full  (fifo_full[k]),
      .empty (fifo_empty[k]),
      .head  (out_data[k*NUBITS +: NUBITS])
    );
  end

  assign in_ready = ~hold_full;

  // One-entry input holding registers; capture and core pop are mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= '0;
      for (int unsigned j = 0; j < NUIOIN; j++) hold_data[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < NUIOIN; j++) begin
        if (in_valid[j] & ~hold_full[j]) begin
          hold_full[j] <= 1'b1;
          hold_data[j] <= in_data[j*NUBITS +: NUBITS];
        end else if (rd_acc & (32'(proc_addr_in) == j)) begin
          hold_full[j] <= 1'b0;
        end
      end
    end
  end

`ifdef IO_TIMEOUT_EN
  localparam int unsigned TW = clog2(TMOUT) + 1;

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = stall_raw & (tmo_cnt == TW'(TMOUT - 1));
  assign io_err  = tmo_hit;

  // Stall watchdog: counts consecutive stalled cycles, clears on release or expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (stall_raw & ~tmo_hit) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign io_err  = 1'b0;
`endif

endmodule

// File: tb/tb_proc_io_hub.sv
// Self-checking bench for proc_io_hub: directed sequences, a vector table and an output scoreboard.
module tb_proc_io_hub;

  localparam int NB = 32;
  localparam int NI = 3;
  localparam int NO = 3;
  localparam int OD = 4;
  localparam int TM = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                proc_out_en;
  logic [1:0]          proc_addr_out;
  logic signed [NB-1:0] proc_data_out;
  logic                proc_req_in;
  logic [1:0]          proc_addr_in;
  logic [NB-1:0]       proc_data_in;
  logic                proc_stall;
  logic [NO*NB-1:0]    out_data;
  logic [NO-1:0]       out_valid;
  logic [NO-1:0]       out_ready;
  logic [NI*NB-1:0]    in_data;
  logic [NI-1:0]       in_valid;
  logic [NI-1:0]       in_ready;
  logic                io_err;

  proc_io_hub #(
    .NUBITS (NB),
    .NUIOIN (NI),
    .NUIOOU (NO),
    .ODEPTH (OD),
    .TMOUT  (TM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .proc_out_en   (proc_out_en),
    .proc_addr_out (proc_addr_out),
    .proc_data_out (proc_data_out),
    .proc_req_in   (proc_req_in),
    .proc_addr_in  (proc_addr_in),
    .proc_data_in  (proc_data_in),
    .proc_stall    (proc_stall),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .io_err        (io_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [NB-1:0] sb0[$];
  logic [NB-1:0] sb1[$];
  logic [NB-1:0] sb2[$];

  typedef struct {
    logic          wr;
    logic [1:0]    wa;
    logic [NB-1:0] wd;
    logic          rd;
    logic [1:0]    ra;
    logic          exp_stall;
    logic          chk_rd;
    logic [NB-1:0] exp_rd;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input int ch, input logic [NB-1:0] d);
    case (ch)
      0: sb0.push_back(d);
      1: sb1.push_back(d);
      2: sb2.push_back(d);
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every handshake pops the channel's expected word.
  always @(negedge clk) begin
    logic [NB-1:0] e;
    logic          got;
    if (!rst) begin
      for (int k = 0; k < NO; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          got = 1'b1;
          e   = '0;
          case (k)
            0: if (sb0.size() > 0) e = sb0.pop_front(); else got = 1'b0;
            1: if (sb1.size() > 0) e = sb1.pop_front(); else got = 1'b0;
            default: if (sb2.size() > 0) e = sb2.pop_front(); else got = 1'b0;
          endcase
          if (!got) begin
            n_chk++;
            n_err++;
            $display("FAIL out_ch%0d_unexpected: got %h expected no word", k, out_data[k*NB +: NB]);
          end else begin
            check($sformatf("out_ch%0d_data", k), out_data[k*NB +: NB], e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Vector table: core ops against preloaded holding regs (A0A0, B1B1, C2C2).
    vt[0] = '{1'b1, 2'd0, 32'h0000_0100, 1'b1, 2'd2, 1'b0, 1'b1, 32'h0000_C2C2};
    vt[1] = '{1'b1, 2'd3, 32'h0000_0999, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0000_0000};
    vt[2] = '{1'b0, 2'd0, 32'h0000_0000, 1'b1, 2'd3, 1'b0, 1'b1, 32'h0000_0000};
    vt[3] = '{1'b0, 2'd0, 32'h0000_0000, 1'b1, 2'd2, 1'b1, 1'b0, 32'h0000_0000};
    vt[4] = '{1'b1, 2'd1, 32'h0000_0200, 1'b1, 2'd0, 1'b0, 1'b1, 32'h0000_A0A0};
    vt[5] = '{1'b1, 2'd3, 32'h0000_0300, 1'b1, 2'd1, 1'b0, 1'b1, 32'h0000_B1B1};
    vt[6] = '{1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0000_0000};
    vt[7] = '{1'b1, 2'd1, 32'h0000_0400, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0000_0000};

    rst = 1'b1;
    proc_out_en = 1'b0; proc_addr_out = '0; proc_data_out = '0;
    proc_req_in = 1'b0; proc_addr_in = '0;
    out_ready = '1; in_data = '0; in_valid = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 3'b000);
    check("rst_in_ready", in_ready, 3'b111);
    check("rst_stall", proc_stall, 1'b0);
    check("rst_io_err", io_err, 1'b0);
    check("rst_data_in", proc_data_in, '0);
    step();

    // Single write to channel 1, drained immediately
    proc_out_en = 1'b1; proc_addr_out = 2'd1; proc_data_out = 32'h0000_0011;
    sb_push(1, 32'h0000_0011);
    @(negedge clk);
    check("t1_stall", proc_stall, 1'b0);
    step();
    proc_out_en = 1'b0;
    @(negedge clk);
    check("t1_valid", out_valid, 3'b010);
    step();
    @(negedge clk);
    check("t1_drained", out_valid, 3'b000);
    step();

    // Fill channel 0 with ready low, then overflow stalls until ready rises
    out_ready = 3'b110;
    for (int v = 1; v <= 4; v++) begin
      proc_out_en = 1'b1; proc_addr_out = 2'd0; proc_data_out = 32'(v);
      sb_push(0, 32'(v));
      @(negedge clk);
      check($sformatf("t2_wr%0d_stall", v), proc_stall, 1'b0);
      step();
    end
    proc_data_out = 32'd5;
    @(negedge clk);
    check("t2_full_stall", proc_stall, 1'b1);
    step();
    @(negedge clk);
    check("t2_full_stall2", proc_stall, 1'b1);
    check("t2_valid0", out_valid, 3'b001);
    step();
    out_ready = 3'b111;
    @(negedge clk);
    check("t2_stall_with_ready", proc_stall, 1'b1);
    step();
    sb_push(0, 32'd5);
    @(negedge clk);
    check("t2_stall_release", proc_stall, 1'b0);
    step();
    proc_out_en = 1'b0;
    for (int i = 0; i < 10 && sb0.size() > 0; i++) step();
    check("t2_drain", 32'(sb0.size()), 32'd0);
    step();

    // Input capture of -7, zero-latency read
    in_data[NB-1:0] = 32'hFFFF_FFF9; in_valid = 3'b001;
    @(negedge clk);
    check("t3_ready_before", in_ready, 3'b111);
    step();
    in_valid = 3'b000;
    proc_req_in = 1'b1; proc_addr_in = 2'd0;
    @(negedge clk);
    check("t3_ready_full", in_ready, 3'b110);
    check("t3_stall", proc_stall, 1'b0);
    check("t3_rdata", proc_data_in, 32'hFFFF_FFF9);
    step();
    proc_req_in = 1'b0;
    @(negedge clk);
    check("t3_ready_after", in_ready, 3'b111);
    check("t3_rdata_idle", proc_data_in, '0);
    step();

    // Blocked read holds a simultaneous unblocked write
    proc_req_in = 1'b1; proc_addr_in = 2'd1;
    proc_out_en = 1'b1; proc_addr_out = 2'd2; proc_data_out = 32'h0000_00AB;
    @(negedge clk);
    check("t4_stall", proc_stall, 1'b1);
    step();
    in_data[2*NB-1:NB] = 32'h0000_0055; in_valid = 3'b010;
    @(negedge clk);
    check("t4_stall2", proc_stall, 1'b1);
    check("t4_no_push", out_valid, 3'b000);
    step();
    in_valid = 3'b000;
    sb_push(2, 32'h0000_00AB);
    @(negedge clk);
    check("t4_release", proc_stall, 1'b0);
    check("t4_rdata", proc_data_in, 32'h0000_0055);
    step();
    proc_req_in = 1'b0; proc_out_en = 1'b0;
    @(negedge clk);
    check("t4_in_ready", in_ready, 3'b111);
    check("t4_out_valid", out_valid, 3'b100);
    step();

    // Table-driven vectors
    in_data = {32'h0000_C2C2, 32'h0000_B1B1, 32'h0000_A0A0}; in_valid = 3'b111;
    step();
    in_valid = 3'b000;
    @(negedge clk);
    check("t5_preload", in_ready, 3'b000);
    step();
    for (int i = 0; i < 8; i++) begin
      proc_out_en = vt[i].wr; proc_addr_out = vt[i].wa; proc_data_out = vt[i].wd;
      proc_req_in = vt[i].rd; proc_addr_in = vt[i].ra;
      if (!vt[i].exp_stall && vt[i].wr && vt[i].wa < 2'd3) sb_push(int'(vt[i].wa), vt[i].wd);
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), proc_stall, vt[i].exp_stall);
      if (vt[i].chk_rd) check($sformatf("vec%0d_rdata", i), proc_data_in, vt[i].exp_rd);
      step();
    end
    proc_out_en = 1'b0; proc_req_in = 1'b0;
    step();
    step();
    @(negedge clk);
    check("t5_out_idle", out_valid, 3'b000);
    check("t5_in_ready", in_ready, 3'b111);
    step();

    // Read of an empty channel: watchdog expiry or indefinite stall
    proc_req_in = 1'b1; proc_addr_in = 2'd0;
`ifdef IO_TIMEOUT_EN
    for (int i = 1; i <= TM; i++) begin
      @(negedge clk);
      check($sformatf("t6_stall_c%0d", i), proc_stall, (i < TM) ? 1'b1 : 1'b0);
      check($sformatf("t6_err_c%0d", i), io_err, (i == TM) ? 1'b1 : 1'b0);
      if (i == TM) check("t6_rdata", proc_data_in, '0);
      step();
    end
`else
    for (int i = 1; i <= TM + 2; i++) begin
      @(negedge clk);
      check($sformatf("t6_stall_c%0d", i), proc_stall, 1'b1);
      check($sformatf("t6_err_c%0d", i), io_err, 1'b0);
      step();
    end
`endif
    proc_req_in = 1'b0;
    @(negedge clk);
    check("t6_after", proc_stall, 1'b0);
    check("t6_in_ready", in_ready, 3'b111);
    step();

    // Reset with words queued and a held input discards everything
    out_ready = 3'b110;
    in_data[3*NB-1:2*NB] = 32'h0000_0077; in_valid = 3'b100;
    for (int v = 0; v < 3; v++) begin
      proc_out_en = 1'b1; proc_addr_out = 2'd0; proc_data_out = 32'(16 + v);
      step();
      in_valid = 3'b000;
    end
    proc_out_en = 1'b0;
    @(negedge clk);
    check("t7_queued", out_valid, 3'b001);
    check("t7_held", in_ready, 3'b011);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t7_rst_valid", out_valid, 3'b000);
    check("t7_rst_ready", in_ready, 3'b111);
    check("t7_rst_stall", proc_stall, 1'b0);
    step();
    out_ready = 3'b111;
    step();
    step();

    check("end_sb0", 32'(sb0.size()), 32'd0);
    check("end_sb1", 32'(sb1.size()), 32'd0);
    check("end_sb2", 32'(sb2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/proc_io_hub.md
Name: proc_io_hub

Overview:
- Buffered multi-channel I/O hub between a processor core's I/O bus (req_in / out_en / addressed port select) and external streaming channels.
- Parametrised successor to the flat per-processor I/O wrapper: N input and M output channels with valid/ready handshakes instead of bare enable strobes.
- Provides a per-output-channel FIFO, a per-input-channel holding register, and a stall back to the core when a transfer cannot complete.
- Sits directly under the per-processor top, in place of the port address decoder.

Parameters:
- NUBITS, 32: data word width.
- NUIOIN, 1: number of input channels (>=1).
- NUIOOU, 2: number of output channels (>=1).
- ODEPTH, 4: output FIFO depth per channel; power of 2, >=2.
- TMOUT, 1024: stall watchdog limit in cycles; used only with IO_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- proc_out_en  in  1  core write strobe.
- proc_addr_out  in  AO=max(1,clog2(NUIOOU))  output channel select.
- proc_data_out  in  NUBITS  write data, signed.
- proc_req_in  in  1  core read strobe.
- proc_addr_in  in  AI=max(1,clog2(NUIOIN))  input channel select.
- proc_data_in  out  NUBITS  read data to the core.
- proc_stall  out  1  core must hold its current I/O instruction.
- out_data  out  NUIOOU*NUBITS  channel k occupies bits [k*NUBITS +: NUBITS].
- out_valid  out  NUIOOU  per-channel valid.
- out_ready  in  NUIOOU  per-channel ready.
- in_data  in  NUIOIN*NUBITS  packed the same way as out_data.
- in_valid  in  NUIOIN  per-channel valid.
- in_ready  out  NUIOIN  per-channel ready.
- io_err  out  1  watchdog error pulse; tied 0 without IO_TIMEOUT_EN.

Behaviour:
- Reset, synchronous:
  - All FIFOs empty, so out_valid=0.
  - All holding registers empty, so in_ready=all 1 from the first cycle after reset.
  - proc_stall=0, io_err=0, watchdog counter=0.
  - Reset mid-transfer discards all buffered data; no partial handshakes survive.
- Stall, combinational:
  - wr_block = proc_out_en & addr valid & FIFO[proc_addr_out] full.
  - rd_block = proc_req_in & addr valid & hold[proc_addr_in] empty.
  - proc_stall = wr_block | rd_block.
- Atomic accept: while proc_stall=1, neither the write nor the read takes effect, even if only one side blocks.
  - Write accept = proc_out_en & ~proc_stall & addr valid: pushes proc_data_out at the clock edge.
  - Read accept = proc_req_in & ~proc_stall & addr valid: pops the holding register at the edge.
- Read data is combinational:
  - proc_data_in = hold[proc_addr_in] whenever proc_req_in=1.
  - Otherwise 0.
  - Zero-latency read, same cycle as the strobe.
- Output FIFO k:
  - out_valid[k] = ~empty; out_data slice = head word.
  - Pops when out_valid & out_ready.
  - Push and pop in the same cycle: when not full, both occur and the count is unchanged; when full, the push is blocked (no bypass), the pop proceeds, and the core retries next cycle.
  - Pointers are log2(ODEPTH) bits and wrap modulo ODEPTH.
  - The count is log2(ODEPTH)+1 bits.
- Input channel j:
  - One-entry register; in_ready[j] = ~full.
  - Captures in_data when in_valid & in_ready.
  - A pop and a new capture cannot occur in the same cycle (ready is low while full), so throughput is 1 word per 2 cycles per channel.
- Out-of-range address (>=NUIOOU or >=NUIOIN):
  - Write is ignored.
  - Read returns 0.
  - Never stalls.
- Write and read in the same cycle are independent apart from the shared stall.

Optional Feature:
- Macro: IO_TIMEOUT_EN.
- With the macro:
  - A counter increments each cycle proc_stall=1 and clears when proc_stall=0.
  - On reaching TMOUT-1 with stall still high:
    - io_err pulses for 1 cycle and proc_stall is forced 0 for that cycle.
    - The blocked write is dropped.
    - A blocked read returns 0 with no pop.
    - The counter clears.
- Without the macro: no counter, io_err tied 0, and stall persists indefinitely.

Decomposition:
- Package proc_io_pkg:
  - clog2 function.
  - AO/AI width helper.
  - Default constants NUBITS_DEF=32 and ODEPTH_DEF=4.
- Sub-module io_fifo:
  - Synchronous FIFO parametrised by NUBITS and ODEPTH.
  - Ports: push, pop, full, empty, head.
  - Instantiated NUIOOU times in a generate loop.
- Input holding registers remain inline.

Test Plan:
- Write 0x0000_0011 to channel 1 with out_ready=1 -> out_valid[1]=1 on the next cycle, data 0x11, popped that cycle, channel 0 untouched.
- out_ready[0]=0, 5 writes to channel 0 with ODEPTH=4 -> writes 1-4 accepted; proc_stall=1 on the 5th; raising out_ready releases the stall the following cycle, and the output order is 1,2,3,4,5.
- in_valid[0]=1 with data -7 -> in_ready drops the next cycle; proc_req_in reads -7 the same cycle with no stall, then in_ready=1.
- proc_req_in on an empty channel with a simultaneous write to a non-full FIFO -> proc_stall=1, write not pushed; after the input arrives, both complete in one cycle.
- Write to address 3 with NUIOOU=2 -> ignored, no stall; rst asserted with 3 words queued -> out_valid=0 the next cycle.
- With IO_TIMEOUT_EN and TMOUT=8, read an empty channel -> io_err pulses once after 8 stalled cycles, proc_data_in=0, stall released.
